// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage that feeds the IF/ID pipeline register. It owns the
// program counter, chooses between sequential PC+4 and a branch redirect, and
// fetches from a variable-latency instruction memory over a req/ack handshake.
// Whenever no valid instruction is available it presents a bubble
// (instr_o = 32'b0, the same encoding IF/ID uses for a flush).
//
// Ports:
//   clk_i            clock, all state updates on the rising edge
//   rst_i            synchronous active-high reset
//   pc_write_i       1 = IF/ID accepts this cycle, 0 = stall
//   branch_i         taken branch/jump, redirect fetch
//   branch_target_i  redirect address (bits [1:0] ignored)
//   imem_req_o       fetch request
//   imem_addr_o      fetch address, stable while a request is outstanding
//   imem_ack_i       memory data valid this cycle
//   imem_data_i      instruction word, valid with imem_ack_i
//   pc_o             PC of the presented instruction
//   instr_o          presented instruction, 32'b0 = bubble
//   fetch_count_o    count of instructions accepted by IF/ID (wraps)
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pc_write_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic [31:0] fetch_count_o
);

  // FETCH   : request outstanding at req_addr_q
  // HOLD    : word accepted from memory but IF/ID stalled; word kept in hold_q
  // DISCARD : redirect arrived mid-request; finish the old handshake, drop data
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] count_q, count_d;

  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        unused_target_bits;

  // Redirect targets are forced to word alignment.
  assign target             = {branch_target_i[31:2], 2'b00};
  assign unused_target_bits = ^branch_target_i[1:0];
  assign pc_plus4           = pc_q + 32'd4;

  // The address register only changes on an ack edge or from HOLD, so the
  // handshake address stays stable for the life of each request.
  assign imem_addr_o   = req_addr_q;
  assign fetch_count_o = rst_i ? 32'd0 : count_q;

  // State register with synchronous reset; a reset mid-request simply drops
  // the request because imem_req_o is forced low while rst_i is high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      hold_q     <= 32'd0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      hold_q     <= hold_d;
      count_q    <= count_d;
    end
  end

  // Next-state and presented outputs. Priority is branch over pc_write; the
  // outputs are combinational so IF/ID samples them at the same edge.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    hold_d     = hold_q;
    count_d    = count_q;
    imem_req_o = 1'b0;
    pc_o       = 32'd0;
    instr_o    = 32'd0;

    if (!rst_i) begin
      case (state_q)
        FETCH: begin
          imem_req_o = 1'b1;
          if (!imem_ack_i) begin
            pc_o = pc_q;
            if (branch_i) begin
              pc_d    = target;
              state_d = DISCARD;
            end
          end else begin
            pc_o = req_addr_q;
            if (branch_i) begin
              // Word arrived on the wrong path: drop it and restart at target.
              pc_d       = target;
              req_addr_d = target;
            end else if (pc_write_i) begin
              instr_o    = imem_data_i;
              pc_d       = pc_plus4;
              req_addr_d = pc_plus4;
              count_d    = count_q + 32'd1;
            end else begin
              // Stall: capture the word so it is never refetched.
              instr_o = imem_data_i;
              hold_d  = imem_data_i;
              state_d = HOLD;
            end
          end
        end

        HOLD: begin
          pc_o = pc_q;
          if (branch_i) begin
            pc_d       = target;
            req_addr_d = target;
            state_d    = FETCH;
          end else if (pc_write_i) begin
            instr_o    = hold_q;
            count_d    = count_q + 32'd1;
            pc_d       = pc_plus4;
            req_addr_d = pc_plus4;
            state_d    = FETCH;
          end else begin
            instr_o = hold_q;
          end
        end

        DISCARD: begin
          imem_req_o = 1'b1;
          pc_o       = pc_q;
          // A later redirect overrides the earlier one.
          if (branch_i) begin
            pc_d = target;
          end
          if (imem_ack_i) begin
            req_addr_d = branch_i ? target : pc_q;
            state_d    = FETCH;
          end
        end

        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
//
// Directed bench for if_fetch_unit with RESET_PC = 0x100. The memory model
// acks on the latency-th consecutive request cycle and returns the word
// addr + 0x0100_0000, so every expected instruction is easy to compute by
// hand. Inputs change just after the falling edge; outputs are checked 1 ns
// later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        pcWrite;
  logic        branch;
  logic [31:0] branchTarget;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic [31:0] pcOut;
  logic [31:0] instrOut;
  logic [31:0] fetchCount;

  int latency;
  int waitCnt;
  int vectors;
  int miscompares;

  if_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .pc_write_i      (pcWrite),
    .branch_i        (branch),
    .branch_target_i (branchTarget),
    .imem_req_o      (imemReq),
    .imem_addr_o     (imemAddr),
    .imem_ack_i      (imemAck),
    .imem_data_i     (imemData),
    .pc_o            (pcOut),
    .instr_o         (instrOut),
    .fetch_count_o   (fetchCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: count request cycles, ack when the count reaches latency.
  assign imemAck  = imemReq && (waitCnt == latency - 1);
  assign imemData = imemAddr + 32'h0100_0000;

  always_ff @(posedge clk) begin
    if (rst || !imemReq || imemAck) waitCnt <= 0;
    else                            waitCnt <= waitCnt + 1;
  end

  task automatic applyStimulus(input logic r, input logic br, input logic [31:0] tgt,
                               input logic pw, input int lat);
    @(negedge clk);
    rst          = r;
    branch       = br;
    branchTarget = tgt;
    pcWrite      = pw;
    latency      = lat;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    branch       = 1'b0;
    branchTarget = 32'd0;
    pcWrite      = 1'b1;
    latency      = 1;

    // Reset held for two cycles; all outputs forced to zero.
    applyStimulus(1, 0, 0, 1, 1);
    applyStimulus(1, 0, 0, 1, 1);
    checkOutput("rst_req",   {31'd0, imemReq}, 32'd0);
    checkOutput("rst_instr", instrOut,   32'd0);
    checkOutput("rst_pc",    pcOut,      32'd0);
    checkOutput("rst_count", fetchCount, 32'd0);

    // Zero-wait memory, continuous accept.
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("seq0_pc",    pcOut,    32'h0000_0100);
    checkOutput("seq0_instr", instrOut, 32'h0100_0100);
    checkOutput("seq0_addr",  imemAddr, 32'h0000_0100);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("seq1_pc",    pcOut,      32'h0000_0104);
    checkOutput("seq1_count", fetchCount, 32'd1);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("seq2_pc",    pcOut,    32'h0000_0108);
    checkOutput("seq2_instr", instrOut, 32'h0100_0108);

    // Latency 3: two bubble cycles with a stable address, then the word.
    applyStimulus(0, 0, 0, 1, 3);
    checkOutput("lat_w1_count", fetchCount, 32'd3);
    checkOutput("lat_w1_instr", instrOut,   32'd0);
    checkOutput("lat_w1_pc",    pcOut,      32'h0000_010C);
    checkOutput("lat_w1_addr",  imemAddr,   32'h0000_010C);
    applyStimulus(0, 0, 0, 1, 3);
    checkOutput("lat_w2_instr", instrOut, 32'd0);
    checkOutput("lat_w2_addr",  imemAddr, 32'h0000_010C);
    checkOutput("lat_w2_req",   {31'd0, imemReq}, 32'd1);
    // Ack arrives with IF/ID stalled -> word goes to HOLD.
    applyStimulus(0, 0, 0, 0, 3);
    checkOutput("lat_ack_instr", instrOut, 32'h0100_010C);
    checkOutput("lat_ack_addr",  imemAddr, 32'h0000_010C);

    // Four stalled cycles: request dropped, held word constant.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 3);
      checkOutput("hold_req",   {31'd0, imemReq}, 32'd0);
      checkOutput("hold_instr", instrOut, 32'h0100_010C);
      checkOutput("hold_pc",    pcOut,    32'h0000_010C);
    end
    // Release: held word accepted exactly once.
    applyStimulus(0, 0, 0, 1, 3);
    checkOutput("rel_instr", instrOut,   32'h0100_010C);
    checkOutput("rel_count", fetchCount, 32'd3);

    // Next request is at +4 (no refetch); redirect in first wait cycle.
    applyStimulus(0, 1, 32'h0000_2003, 1, 3);
    checkOutput("br_addr",  imemAddr,   32'h0000_0110);
    checkOutput("br_count", fetchCount, 32'd4);
    checkOutput("br_pc",    pcOut,      32'h0000_0110);
    checkOutput("br_instr", instrOut,   32'd0);
    applyStimulus(0, 0, 0, 1, 3);
    checkOutput("disc_addr",  imemAddr, 32'h0000_0110);
    checkOutput("disc_req",   {31'd0, imemReq}, 32'd1);
    checkOutput("disc_pc",    pcOut,    32'h0000_2000);
    checkOutput("disc_instr", instrOut, 32'd0);
    applyStimulus(0, 0, 0, 1, 3);
    checkOutput("disc_ack_instr", instrOut, 32'd0);
    checkOutput("disc_ack_addr",  imemAddr, 32'h0000_0110);

    // Fetch resumes at the aligned target; branch coincident with ack while
    // stalled drops the word and leaves the count alone.
    applyStimulus(0, 1, 32'h0000_3000, 0, 1);
    checkOutput("tgt_addr",   imemAddr,   32'h0000_2000);
    checkOutput("tgt_pc",     pcOut,      32'h0000_2000);
    checkOutput("tgt_instr",  instrOut,   32'd0);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("br2_addr",   imemAddr,   32'h0000_3000);
    checkOutput("br2_instr",  instrOut,   32'h0100_3000);
    checkOutput("br2_count",  fetchCount, 32'd4);

    // Redirect to the top of the address space and wrap.
    applyStimulus(0, 1, 32'hFFFF_FFFE, 1, 1);
    checkOutput("br3_pc",    pcOut,      32'h0000_3004);
    checkOutput("br3_instr", instrOut,   32'd0);
    checkOutput("br3_count", fetchCount, 32'd5);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("top_pc",    pcOut,    32'hFFFF_FFFC);
    checkOutput("top_instr", instrOut, 32'h00FF_FFFC);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("wrap_pc",    pcOut,      32'h0000_0000);
    checkOutput("wrap_instr", instrOut,   32'h0100_0000);
    checkOutput("wrap_count", fetchCount, 32'd6);

    // Enter DISCARD, then reset while the request is outstanding.
    applyStimulus(0, 1, 32'h0000_0500, 1, 3);
    checkOutput("d2_pc", pcOut, 32'h0000_0004);
    applyStimulus(0, 0, 0, 1, 3);
    checkOutput("d2_addr",  imemAddr,   32'h0000_0004);
    checkOutput("d2_pc2",   pcOut,      32'h0000_0500);
    checkOutput("d2_count", fetchCount, 32'd7);
    applyStimulus(1, 0, 0, 1, 3);
    checkOutput("rst2_req",   {31'd0, imemReq}, 32'd0);
    checkOutput("rst2_instr", instrOut,   32'd0);
    checkOutput("rst2_pc",    pcOut,      32'd0);
    checkOutput("rst2_count", fetchCount, 32'd0);

    // After reset: fetch at RESET_PC, stall into HOLD, then branch out of HOLD.
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("post_addr",  imemAddr,   32'h0000_0100);
    checkOutput("post_instr", instrOut,   32'h0100_0100);
    checkOutput("post_count", fetchCount, 32'd0);
    applyStimulus(0, 1, 32'h0000_0040, 1, 1);
    checkOutput("hbr_req",   {31'd0, imemReq}, 32'd0);
    checkOutput("hbr_instr", instrOut, 32'd0);
    checkOutput("hbr_pc",    pcOut,    32'h0000_0100);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("hbr_addr",  imemAddr,   32'h0000_0040);
    checkOutput("hbr_tinst", instrOut,   32'h0100_0040);
    checkOutput("hbr_count", fetchCount, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
